// File: rtl/modulation_scheduler_if.sv
// Bus bundle for the modulation scheduler: sweep request, per-channel duty in,
// modulated duty out and status flags.
interface modulation_scheduler_if #(
    parameter int WIDTH = 13,
    parameter int DEPTH = 249
);
    logic             UPDATE;
    logic [7:0]       MOD;
    logic [WIDTH-1:0] DUTY   [0:DEPTH-1];
    logic             CLR_OVERRUN;
    logic [WIDTH-1:0] DUTY_M [0:DEPTH-1];
    logic             OUT_VALID;
    logic             BUSY;
    logic             OVERRUN;

    modport master (
        output UPDATE, MOD, DUTY, CLR_OVERRUN,
        input  DUTY_M, OUT_VALID, BUSY, OVERRUN
    );

    modport slave (
        input  UPDATE, MOD, DUTY, CLR_OVERRUN,
        output DUTY_M, OUT_VALID, BUSY, OVERRUN
    );
endinterface

// File: rtl/modulation_scheduler.sv
// Time-multiplexed amplitude modulation: one shared pipelined multiplier walks all
// channels into a shadow buffer, then DUTY_M is committed in a single cycle.
module modulation_scheduler #(
    parameter int WIDTH        = 13,
    parameter int DEPTH        = 249,
    parameter int MULT_LATENCY = 2
) (
    input  logic                  CLK,
    input  logic                  RST_N,
    modulation_scheduler_if.slave bus
);
    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = (MULT_LATENCY > 1) ? $clog2(MULT_LATENCY) : 1;
    localparam int PW    = WIDTH + 9;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(MULT_LATENCY - 1);

    typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_DRAIN, S_COMMIT} state_t;

    state_t           state_q, state_d;
    logic [IDX_W-1:0] idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [8:0]       m_q, m_d;
    logic             overrun_q, overrun_d;
    logic             busy_q, busy_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] shadow_q [DEPTH];
    logic [WIDTH-1:0] shadow_d [DEPTH];
    logic [WIDTH-1:0] duty_m_q [DEPTH];
    logic [WIDTH-1:0] duty_m_d [DEPTH];
    logic [WIDTH-1:0] scaled;

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        cnt_d     = cnt_q;
        m_d       = m_q;
        overrun_d = overrun_q;
        // Clear is applied first so a coincident overrun below takes priority.
        if (bus.CLR_OVERRUN) overrun_d = 1'b0;
        unique case (state_q)
            S_IDLE, S_COMMIT: begin
                if (bus.UPDATE) begin
                    state_d = S_ISSUE;
                    m_d     = {1'b0, bus.MOD} + 9'd1;
                    idx_d   = '0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (bus.UPDATE) overrun_d = 1'b1;
                if (idx_q == LAST_IDX) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                end else begin
                    idx_d = idx_q + IDX_W'(1);
                end
            end
            S_DRAIN: begin
                if (bus.UPDATE) overrun_d = 1'b1;
                if (cnt_q == LAST_CNT) state_d = S_COMMIT;
                else                   cnt_d   = cnt_q + CNT_W'(1);
            end
            default: state_d = S_IDLE;
        endcase
        busy_d      = (state_d != S_IDLE);
        out_valid_d = (state_q == S_COMMIT);
    end

    // Product never exceeds WIDTH+8 bits, so the >>8 result always fits in WIDTH.
    always_comb begin
        scaled = WIDTH'((PW'(bus.DUTY[idx_q]) * PW'(m_q)) >> 8);
    end

    genvar gi;
    generate
        for (gi = 0; gi < MULT_LATENCY; gi++) begin : g_stage
            logic             vld_q, vld_d;
            logic [IDX_W-1:0] tag_q, tag_d;
            logic [WIDTH-1:0] data_q, data_d;
            if (gi == 0) begin : g_head
                always_comb begin
                    vld_d  = (state_q == S_ISSUE);
                    tag_d  = idx_q;
                    data_d = scaled;
                end
            end else begin : g_body
                always_comb begin
                    vld_d  = g_stage[gi-1].vld_q;
                    tag_d  = g_stage[gi-1].tag_q;
                    data_d = g_stage[gi-1].data_q;
                end
            end
            always_ff @(posedge CLK or negedge RST_N) begin
                if (!RST_N) begin
                    vld_q  <= 1'b0;
                    tag_q  <= '0;
                    data_q <= '0;
                end else begin
                    vld_q  <= vld_d;
                    tag_q  <= tag_d;
                    data_q <= data_d;
                end
            end
        end
    endgenerate

    always_comb begin
        shadow_d = shadow_q;
        if (g_stage[MULT_LATENCY-1].vld_q)
            shadow_d[g_stage[MULT_LATENCY-1].tag_q] = g_stage[MULT_LATENCY-1].data_q;
        duty_m_d = duty_m_q;
        if (state_q == S_COMMIT) duty_m_d = shadow_q;
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q     <= S_IDLE;
            idx_q       <= '0;
            cnt_q       <= '0;
            m_q         <= '0;
            overrun_q   <= 1'b0;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b0;
            for (int i = 0; i < DEPTH; i++) begin
                shadow_q[i] <= '0;
                duty_m_q[i] <= '0;
            end
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            cnt_q       <= cnt_d;
            m_q         <= m_d;
            overrun_q   <= overrun_d;
            busy_q      <= busy_d;
            out_valid_q <= out_valid_d;
            shadow_q    <= shadow_d;
            duty_m_q    <= duty_m_d;
        end
    end

    assign bus.DUTY_M    = duty_m_q;
    assign bus.OUT_VALID = out_valid_q;
    assign bus.BUSY      = busy_q;
    assign bus.OVERRUN   = overrun_q;
endmodule

// File: doc/modulation_scheduler.md
# modulation_scheduler

Time-multiplexed amplitude-modulation engine for the transducer duty datapath. It replaces a per-channel multiplier array with one shared pipelined multiplier. On each sampler `UPDATE` strobe it latches the current 8-bit `MOD` sample, walks all `DEPTH` duty channels through the multiplier, and collects the products in a shadow buffer. It then commits all channels to `DUTY_M` in a single cycle with an `OUT_VALID` pulse. It sits between the modulation sampler/buffer and the PWM stage.

## Interface
- `WIDTH`, 13: duty word width.
- `DEPTH`, 249: number of transducer channels.
- `MULT_LATENCY`, 2: pipeline stages in the shared multiplier. Must be ≥1.

- `CLK`  in  1  system clock; single clock domain.
- `RST_N`  in  1  asynchronous, active-low reset.
- `UPDATE`  in  1  one-cycle strobe from the sampler requesting a new modulation sweep.
- `MOD`  in  8  modulation sample; sampled only in the cycle `UPDATE` is accepted.
- `DUTY[0:DEPTH-1]`  in  `WIDTH` each  unmodulated duty per channel; channel k is sampled in its issue cycle.
- `CLR_OVERRUN`  in  1  one-cycle clear for `OVERRUN`.
- `DUTY_M[0:DEPTH-1]`  out  `WIDTH` each  modulated duty; all channels change together.
- `OUT_VALID`  out  1  one-cycle pulse in the cycle `DUTY_M` takes new values.
- `BUSY`  out  1  high while a sweep is in progress (ISSUE, DRAIN or COMMIT).
- `OVERRUN`  out  1  sticky flag: an `UPDATE` arrived while a sweep was running and was dropped.

## Operation
- **States:**
  - IDLE: waiting for `UPDATE`.
  - ISSUE: `DEPTH` cycles, index `idx` = 0..DEPTH-1.
  - DRAIN: `MULT_LATENCY` cycles.
  - COMMIT: 1 cycle.
- **IDLE → ISSUE:** on `UPDATE`. Latch `m = MOD + 1` (9 bits, range 1..256) and set `idx` = 0.
- **ISSUE:** each cycle, present `DUTY[idx]` and `m` to the multiplier and push `idx` down a tag pipeline of depth `MULT_LATENCY`.
  - When `idx` = DEPTH-1, go to DRAIN.
  - The `idx` counter is `$clog2(DEPTH)` bits and never wraps past DEPTH-1.
- **Arithmetic:** product P = `DUTY[k]` × m, (`WIDTH`+9) bits.
  - Result = P[`WIDTH`+7:8], i.e. floor(`DUTY`·(`MOD`+1)/256).
  - The result cannot overflow `WIDTH` bits. `MOD`=255 reproduces `DUTY` exactly; `MOD`=0 gives floor(`DUTY`/256).
- **Write-back:** each pipeline output is written to shadow[tag] in the cycle it emerges. `DUTY_M` is untouched until COMMIT.
- **DRAIN:** lasts exactly `MULT_LATENCY` cycles, then go to COMMIT.
- **COMMIT:** copy shadow → `DUTY_M` for all channels and pulse `OUT_VALID`. Go to IDLE, or straight to ISSUE if `UPDATE` is high in this cycle.
- **Overrun:** `UPDATE` during ISSUE or DRAIN is dropped and sets `OVERRUN`.
  - `UPDATE` during COMMIT is accepted: the new `MOD` is latched, and the commit of the previous sweep still completes.
  - If `CLR_OVERRUN` and a new overrun coincide, set wins.
- **Reset (asynchronous, any time, including mid-sweep):**
  - State → IDLE; `DUTY_M` and shadow → 0.
  - `OUT_VALID`, `BUSY`, `OVERRUN` → 0; multiplier tag-valid bits → 0.
  - No `OUT_VALID` appears after reset release until a new `UPDATE` completes a full sweep.

## Timing
- Let e0 be the clock edge that samples `UPDATE` high in IDLE.
- **Issue:** channel k is issued at edge e(k+1) and written to shadow at edge e(k+1+`MULT_LATENCY`).
- **Commit:** `DUTY_M` updates and `OUT_VALID` rises at edge e(DEPTH+MULT_LATENCY+1). `OUT_VALID` falls at the next edge.
  - Defaults: edge e252.
- **BUSY:** high from e0 until the edge after COMMIT. It is high for exactly DEPTH+MULT_LATENCY+1 cycles, unless chained.
- **Throughput:** minimum `UPDATE` spacing without overrun is DEPTH+MULT_LATENCY+1 cycles (252 at defaults). Back-to-back chaining via COMMIT achieves exactly this spacing.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
1. **Identity:** reset, `DUTY[k]`=k·32 mod 8192, `MOD`=255, one `UPDATE` → `OUT_VALID` exactly 252 edges later; `DUTY_M[k]`=`DUTY[k]` for all k; `BUSY` high 252 cycles.
2. **Scaling:** `DUTY`=all 8191, `MOD`=127 → `DUTY_M`=4095 everywhere. Then `MOD`=0 → 31. `DUTY`=0, `MOD`=200 → 0.
3. **Overrun:** `UPDATE` at e0 with `MOD`=255, again at e100 with `MOD`=0 → second dropped; `OVERRUN`=1; `DUTY_M` reflects `MOD`=255; single `OUT_VALID`. Then `CLR_OVERRUN` → `OVERRUN`=0. Then `CLR_OVERRUN` coinciding with a new overrun → `OVERRUN` stays 1.
4. **Chaining:** second `UPDATE` exactly in the COMMIT cycle (`MOD` 255 then 63) → two `OUT_VALID` pulses 252 cycles apart, no overrun; second result = floor(`DUTY`/4).
5. **Mid-sweep reset:** assert `RST_N` low at e120 → `DUTY_M`=0, `BUSY`=0 immediately; no `OUT_VALID` afterwards; a fresh `UPDATE` yields correct results 252 edges later.
6. **Issue-time sampling:** change `DUTY[200]` from 100 to 8000 at e150 during a `MOD`=255 sweep → `DUTY_M[200]`=8000, `DUTY_M[10]`=old value; both become visible only at commit.
